// File: rtl/spectrum_postproc.sv
`default_nettype none
// ============================================================================
//  Module   : spectrum_postproc
//  Purpose  : Per-bin temporal post-processor for an FFT magnitude stream.
//             Keeps an exponential moving average and a decaying peak-hold
//             for every bin in internal RAM. Emits one processed value per
//             input bin, in the same address order, two cycles after input.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_addr/in_data/in_ready : magnitude input stream
//             mode (0 bypass, 1 avg, 2 peak, 3 peak of avg), clr (clear pulse)
//             out_valid/out_addr/out_data       : processed stream
//             frame_done : pulse with the output of bin BINS-1
//             max_bin/max_val : per-frame maximum (SPECTRUM_PEAKBIN_EN)
//  Options  : `define SPECTRUM_PEAKBIN_EN builds the per-frame max tracker;
//             without it max_bin/max_val are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module spectrum_postproc #(
    parameter int BINS         = 256,
    parameter int ADDR_W       = 8,
    parameter int MAG_W        = 9,
    parameter int AVG_SHIFT    = 2,
    parameter int DECAY_FRAMES = 4,
    parameter int DECAY_STEP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [MAG_W-1:0]  in_data,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic              clr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [MAG_W-1:0]  out_data,
    output logic              frame_done,
    output logic [ADDR_W-1:0] max_bin,
    output logic [MAG_W-1:0]  max_val
);

    localparam int                c_acc_w     = MAG_W + AVG_SHIFT;
    localparam int                c_ph_w      = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(BINS - 1);
    localparam logic [c_ph_w-1:0] c_ph_last   = c_ph_w'(DECAY_FRAMES - 1);
    localparam logic [MAG_W-1:0]  c_step      = MAG_W'(DECAY_STEP);

    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_run   = 1'b1;

    logic [0:0]        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [c_ph_w-1:0] r_phase;      // (completed frames) mod DECAY_FRAMES

    logic [c_acc_w-1:0] r_avg_ram [BINS];
    logic [MAG_W-1:0]   r_pk_ram  [BINS];

    // S1: accepted sample plus RAM (or forwarded) state
    logic               r_s1_valid;
    logic [ADDR_W-1:0]  r_s1_addr;
    logic [MAG_W-1:0]   r_s1_x;
    logic [1:0]         r_s1_mode;
    logic [c_acc_w-1:0] r_s1_acc;
    logic [MAG_W-1:0]   r_s1_pk;

    // S2: computed results, written back and presented on the outputs
    logic               r_s2_valid;
    logic [ADDR_W-1:0]  r_s2_addr;
    logic [MAG_W-1:0]   r_s2_out;
    logic [c_acc_w-1:0] r_s2_acc;
    logic [MAG_W-1:0]   r_s2_pk;

    logic               w_accept, w_s2_wb, w_s2_last, w_fwd0, w_fwd1, w_decay;
    logic [c_ph_w-1:0]  w_phase_nxt, w_phase_eff;
    logic [c_acc_w-1:0] w_acc_old, w_acc_new;
    logic [MAG_W-1:0]   w_pk_old, w_pk_dec, w_avg, w_src, w_pk_new, w_out;
    logic               w_ram_we;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic [c_acc_w-1:0] w_ram_acc;
    logic [MAG_W-1:0]   w_ram_pk;

    // ------------------------------------------------------------------ FSM
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            c_st_clear: begin
                if (!clr && (r_clr_addr == c_last_addr)) w_state_nxt = c_st_run;
            end
            default: begin
                in_ready = 1'b1;
                if (clr) w_state_nxt = c_st_clear;
            end
        endcase
    end

    assign w_accept = in_valid & in_ready & ~clr;

    // clr kills the sample sitting in S2 as well, so nothing that was in the
    // pipeline when clr arrived ever reaches the output or the RAM.
    assign w_s2_wb   = r_s2_valid & ~clr;
    assign w_s2_last = w_s2_wb & (r_s2_addr == c_last_addr);

    // A sample in S1 belongs to the frame after a bin BINS-1 sitting in S2,
    // even though that frame-end has not been counted yet.
    assign w_phase_nxt = (r_phase == c_ph_last) ? '0 : r_phase + c_ph_w'(1);
    assign w_phase_eff = w_s2_last ? w_phase_nxt : r_phase;
    assign w_decay     = (w_phase_eff == c_ph_last);

    // Forwarding: S0 picks up the S2 write-back that the RAM read misses;
    // S1 picks up the result of the sample directly ahead of it.
    assign w_fwd0 = r_s2_valid & (r_s2_addr == in_addr);
    assign w_fwd1 = r_s2_valid & (r_s2_addr == r_s1_addr);

    // ------------------------------------------------------------ S1 compute
    always_comb begin
        w_acc_old = w_fwd1 ? r_s2_acc : r_s1_acc;
        w_pk_old  = w_fwd1 ? r_s2_pk  : r_s1_pk;
        w_acc_new = w_acc_old - (w_acc_old >> AVG_SHIFT) + c_acc_w'(r_s1_x);
        w_avg     = MAG_W'(w_acc_new >> AVG_SHIFT);
        w_pk_dec  = w_pk_old;
        if (w_decay) w_pk_dec = (w_pk_old > c_step) ? (w_pk_old - c_step) : '0;
        w_src     = (r_s1_mode == 2'd3) ? w_avg : r_s1_x;
        w_pk_new  = (w_src > w_pk_dec) ? w_src : w_pk_dec;
        case (r_s1_mode)
            2'd0:    w_out = r_s1_x;
            2'd1:    w_out = w_avg;
            default: w_out = w_pk_new;
        endcase
    end

    // Single write port shared by the clear sweep and the S2 write-back
    always_comb begin
        w_ram_we   = 1'b0;
        w_ram_addr = r_s2_addr;
        w_ram_acc  = r_s2_acc;
        w_ram_pk   = r_s2_pk;
        if (r_state == c_st_clear) begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_clr_addr;
            w_ram_acc  = '0;
            w_ram_pk   = '0;
        end else if (w_s2_wb) begin
            w_ram_we   = 1'b1;
        end
    end

    // --------------------------------------------------------- control regs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_clear;
            r_clr_addr <= '0;
            r_phase    <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_out   <= '0;
            r_s2_acc   <= '0;
            r_s2_pk    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_st_clear) && !clr) r_clr_addr <= r_clr_addr + ADDR_W'(1);
            else                                  r_clr_addr <= '0;
            if (r_state == c_st_clear) r_phase <= '0;
            else if (w_s2_last)        r_phase <= w_phase_nxt;
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid & ~clr;
            if (r_s1_valid) begin
                r_s2_addr <= r_s1_addr;
                r_s2_out  <= w_out;
                r_s2_acc  <= w_acc_new;
                r_s2_pk   <= w_pk_new;
            end
        end
    end

    // ------------------------------------------------------ RAM and S0 read
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_avg_ram[w_ram_addr] <= w_ram_acc;
            r_pk_ram[w_ram_addr]  <= w_ram_pk;
        end
        if (w_accept) begin
            r_s1_addr <= in_addr;
            r_s1_x    <= in_data;
            r_s1_mode <= mode;
            r_s1_acc  <= w_fwd0 ? r_s2_acc : r_avg_ram[in_addr];
            r_s1_pk   <= w_fwd0 ? r_s2_pk  : r_pk_ram[in_addr];
        end
    end

    assign out_valid  = w_s2_wb;
    assign out_addr   = r_s2_addr;
    assign out_data   = r_s2_out;
    assign frame_done = w_s2_last;

`ifdef SPECTRUM_PEAKBIN_EN
    logic [ADDR_W-1:0] r_run_bin, r_max_bin;
    logic [MAG_W-1:0]  r_run_val, r_max_val;
    logic              r_run_empty;
    logic              w_take;

    // First sample of a frame always seeds the max; afterwards only a
    // strictly larger value replaces it, so the lowest bin wins ties.
    assign w_take = r_run_empty | (r_s2_out > r_run_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_bin   <= '0;
            r_run_val   <= '0;
            r_run_empty <= 1'b1;
            r_max_bin   <= '0;
            r_max_val   <= '0;
        end else if (r_state == c_st_clear) begin
            r_run_bin   <= '0;
            r_run_val   <= '0;
            r_run_empty <= 1'b1;
            r_max_bin   <= '0;
            r_max_val   <= '0;
        end else if (w_s2_wb) begin
            if (w_s2_last) begin
                r_max_bin   <= w_take ? r_s2_addr : r_run_bin;
                r_max_val   <= w_take ? r_s2_out  : r_run_val;
                r_run_empty <= 1'b1;
            end else if (w_take) begin
                r_run_bin   <= r_s2_addr;
                r_run_val   <= r_s2_out;
                r_run_empty <= 1'b0;
            end
        end
    end

    assign max_bin = r_max_bin;
    assign max_val = r_max_val;
`else
    assign max_bin = '0;
    assign max_val = '0;
`endif

endmodule
`default_nettype wire
